// File: rtl/cardinal_nic_pkg.sv
// Shared definitions for the parametrised cardinal ring NIC.
// Address map, status bit positions and width helpers.
package cardinal_nic_pkg;

   localparam int NIC_DATA_W = 64;

   typedef enum logic [1:0] {
      ADDR_IN_DATA  = 2'b00,
      ADDR_IN_STAT  = 2'b01,
      ADDR_OUT_DATA = 2'b10,
      ADDR_OUT_STAT = 2'b11
   } nic_addr_e;

   localparam int STAT_FLAG = 0;
   localparam int STAT_DROP = NIC_DATA_W - 1;
   localparam int VC_BIT    = NIC_DATA_W - 1;

   // Top bit of a W-wide word: VC bit of a packet, drop bit of a status word.
   function automatic int msb_of(input int w);
      return w - 1;
   endfunction

   // Occupancy counter width able to hold 0..depth.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/cardinal_sync_fifo.sv
// Synchronous FIFO with occupancy count, used for both NIC directions.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module cardinal_sync_fifo
   import cardinal_nic_pkg::*;
#(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_din,
   output logic [W-1:0]             o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [cnt_w(DEPTH)-1:0]  o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = cnt_w(DEPTH);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd;
   logic [PTR_W-1:0] r_wr;
   logic [CW-1:0]    r_cnt;

   logic w_pop;
   logic w_push;

   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_count = r_cnt;
   assign o_head  = r_mem[r_rd];

   // Underflow and overflow are suppressed here so callers may request freely.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   // Storage, pointers and count; pointers wrap because DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_din;
            r_wr        <= r_wr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd <= r_rd + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/cardinal_nic_param.sv
// NIC between a cpu node and its cardinal ring router port.
// FIFO-buffered in both directions, polarity-gated injection, sticky drop flags.
module cardinal_nic_param
   import cardinal_nic_pkg::*;
#(
   parameter int DATA_W    = NIC_DATA_W,
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              nicEn,
   input  logic              nicWrEn,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   input  logic              net_si,
   output logic              net_ri,
   input  logic [DATA_W-1:0] net_di,
   output logic              net_so,
   input  logic              net_ro,
   output logic [DATA_W-1:0] net_do,
   input  logic              net_polarity
);

   localparam int IN_CW  = cnt_w(IN_DEPTH);
   localparam int OUT_CW = cnt_w(OUT_DEPTH);
   localparam int VC_B   = msb_of(DATA_W);
   localparam int DROP_B = msb_of(DATA_W);

   logic [DATA_W-1:0] w_in_head;
   logic              w_in_full;
   logic              w_in_empty;
   logic [IN_CW-1:0]  w_in_cnt;
   logic              w_in_push;
   logic              w_in_pop;
   logic              w_in_drop;
   logic              w_in_clr;

   logic [DATA_W-1:0] w_out_head;
   logic              w_out_full;
   logic              w_out_empty;
   logic [OUT_CW-1:0] w_out_cnt;
   logic              w_out_wr;
   logic              w_out_pop;
   logic              w_out_drop;
   logic              w_out_clr;

   logic              w_rd;
   logic              w_wr;
   logic [DATA_W-1:0] w_dout;

   logic              r_net_so;
   logic [DATA_W-1:0] r_net_do;
   logic              r_in_drop;
   logic              r_out_drop;

   assign w_rd = nicEn & ~nicWrEn;
   assign w_wr = nicEn & nicWrEn;

   // Network -> cpu: ready comes from registered occupancy only.
   assign net_ri    = ~w_in_full;
   assign w_in_push = net_si & net_ri;
   assign w_in_drop = net_si & ~net_ri;
   assign w_in_pop  = w_rd & (addr == ADDR_IN_DATA) & ~w_in_empty;
   assign w_in_clr  = w_rd & (addr == ADDR_IN_STAT);

   // Cpu -> network: head leaves only when its VC matches the ring phase.
   assign w_out_wr   = w_wr & (addr == ADDR_OUT_DATA);
   assign w_out_pop  = ~w_out_empty & net_ro
                     & (w_out_head[VC_B] == net_polarity);
   assign w_out_drop = w_out_wr & w_out_full & ~w_out_pop;
   assign w_out_clr  = w_rd & (addr == ADDR_OUT_STAT);

   cardinal_sync_fifo #(
      .W     (DATA_W),
      .DEPTH (IN_DEPTH)
   ) u_in_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_in_push),
      .i_pop   (w_in_pop),
      .i_din   (net_di),
      .o_head  (w_in_head),
      .o_full  (w_in_full),
      .o_empty (w_in_empty),
      .o_count (w_in_cnt)
   );

   cardinal_sync_fifo #(
      .W     (DATA_W),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_out_wr),
      .i_pop   (w_out_pop),
      .i_din   (d_in),
      .o_head  (w_out_head),
      .o_full  (w_out_full),
      .o_empty (w_out_empty),
      .o_count (w_out_cnt)
   );

   // Injection register: valid pulses per popped packet, data holds otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_net_so <= 1'b0;
         r_net_do <= '0;
      end else begin
         r_net_so <= w_out_pop;
         if (w_out_pop) begin
            r_net_do <= w_out_head;
         end
      end
   end

   // Sticky drop flags; a new drop wins over a clearing status read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_in_drop  <= 1'b0;
         r_out_drop <= 1'b0;
      end else begin
         r_in_drop  <= w_in_drop | (r_in_drop & ~w_in_clr);
         r_out_drop <= w_out_drop | (r_out_drop & ~w_out_clr);
      end
   end

   // Cpu read mux; zero whenever there is no read access.
   always_comb begin
      w_dout = '0;
      if (w_rd) begin
         unique case (addr)
            ADDR_IN_DATA: begin
               if (!w_in_empty) begin
                  w_dout = w_in_head;
               end
            end
            ADDR_IN_STAT: begin
               w_dout[STAT_FLAG]  = ~w_in_empty;
               w_dout[IN_CW:1]    = w_in_cnt;
               w_dout[DROP_B]     = r_in_drop;
            end
            ADDR_OUT_STAT: begin
               w_dout[STAT_FLAG]  = w_out_full;
               w_dout[OUT_CW:1]   = w_out_cnt;
               w_dout[DROP_B]     = r_out_drop;
            end
            default: begin
               w_dout = '0;
            end
         endcase
      end
   end

   assign d_out  = w_dout;
   assign net_so = r_net_so;
   assign net_do = r_net_do;

endmodule

// File: tb/tb_cardinal_nic_param.sv
// Directed bench for cardinal_nic_param (DATA_W=64, depths 4).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_cardinal_nic_param;

   logic        clk;
   logic        reset;
   logic        nicEn;
   logic        nicWrEn;
   logic [1:0]  addr;
   logic [63:0] d_in;
   logic [63:0] d_out;
   logic        net_si;
   logic        net_ri;
   logic [63:0] net_di;
   logic        net_so;
   logic        net_ro;
   logic [63:0] net_do;
   logic        net_polarity;

   int checks = 0;
   int errors = 0;

   logic [63:0] rd;
   logic        pol_prev;
   logic        sent;
   logic        exp_so;
   int          idx;

   localparam logic [63:0] PKT_A = 64'h8000_0000_0000_00AA;

   cardinal_nic_param #(
      .DATA_W    (64),
      .IN_DEPTH  (4),
      .OUT_DEPTH (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .nicEn        (nicEn),
      .nicWrEn      (nicWrEn),
      .addr         (addr),
      .d_in         (d_in),
      .d_out        (d_out),
      .net_si       (net_si),
      .net_ri       (net_ri),
      .net_di       (net_di),
      .net_so       (net_so),
      .net_ro       (net_ro),
      .net_do       (net_do),
      .net_polarity (net_polarity)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      net_polarity = ~net_polarity;
   endtask

   task automatic cpu_wr(input logic [1:0] a, input logic [63:0] d);
      nicEn   = 1'b1;
      nicWrEn = 1'b1;
      addr    = a;
      d_in    = d;
      step();
      nicEn   = 1'b0;
      nicWrEn = 1'b0;
   endtask

   task automatic cpu_rd(input logic [1:0] a, output logic [63:0] d);
      nicEn   = 1'b1;
      nicWrEn = 1'b0;
      addr    = a;
      #1;
      d = d_out;
      step();
      nicEn = 1'b0;
   endtask

   initial begin
      reset        = 1'b0;
      nicEn        = 1'b0;
      nicWrEn      = 1'b0;
      addr         = 2'b00;
      d_in         = '0;
      net_si       = 1'b0;
      net_di       = '0;
      net_ro       = 1'b0;
      net_polarity = 1'b0;
      #1;
      chk("rst_so", 64'(net_so), 64'd0);
      chk("rst_do", net_do, 64'd0);
      chk("rst_ri", 64'(net_ri), 64'd1);
      chk("rst_dout", d_out, 64'd0);
      step();
      step();
      reset = 1'b1;

      // T2: VC=1 packet leaves only after a polarity==1 cycle
      net_ro = 1'b1;
      cpu_wr(2'b10, PKT_A);
      sent = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pol_prev = net_polarity;
         step();
         exp_so = pol_prev & ~sent;
         chk("t2_so", 64'(net_so), 64'(exp_so));
         if (exp_so) begin
            chk("t2_do", net_do, PKT_A);
            sent = 1'b1;
         end
      end
      net_ro = 1'b0;

      // T3: out overflow with router stalled
      for (int k = 1; k <= 5; k++) begin
         cpu_wr(2'b10, 64'(k));
      end
      cpu_rd(2'b11, rd);
      chk("t3_stat1", rd, 64'h8000_0000_0000_0009);
      cpu_rd(2'b11, rd);
      chk("t3_stat2", rd, 64'h0000_0000_0000_0009);
      net_ro = 1'b1;
      idx = 0;
      for (int i = 0; i < 16; i++) begin
         pol_prev = net_polarity;
         step();
         exp_so = ~pol_prev & (idx < 4);
         chk("t3_so", 64'(net_so), 64'(exp_so));
         if (exp_so) begin
            chk("t3_do", net_do, 64'(idx + 1));
            idx++;
         end
      end
      net_ro = 1'b0;
      cpu_rd(2'b11, rd);
      chk("t3_stat3", rd, 64'd0);

      // T1: reset in the middle of a transfer
      cpu_wr(2'b10, 64'h11);
      cpu_wr(2'b10, 64'h12);
      cpu_wr(2'b10, 64'h13);
      net_ro = 1'b1;
      for (int i = 0; i < 4 && !net_so; i++) begin
         step();
      end
      chk("t1_so_pre", 64'(net_so), 64'd1);
      chk("t1_do_pre", net_do, 64'h11);
      reset = 1'b0;
      #1;
      chk("t1_so_async", 64'(net_so), 64'd0);
      chk("t1_do_async", net_do, 64'd0);
      nicEn   = 1'b1;
      nicWrEn = 1'b0;
      addr    = 2'b11;
      #1;
      chk("t1_stat_rst", d_out, 64'd0);
      nicEn = 1'b0;
      step();
      reset = 1'b1;
      #1;
      chk("t1_ri", 64'(net_ri), 64'd1);
      cpu_rd(2'b11, rd);
      chk("t1_stat", rd, 64'd0);
      step();
      chk("t1_so_post", 64'(net_so), 64'd0);
      net_ro = 1'b0;

      // T4: in backpressure and drop
      net_si = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         net_di = 64'(k);
         step();
      end
      net_si = 1'b0;
      chk("t4_ri_full", 64'(net_ri), 64'd0);
      cpu_rd(2'b01, rd);
      chk("t4_stat_full", rd, 64'h0000_0000_0000_0009);
      net_si = 1'b1;
      net_di = 64'h99;
      step();
      net_si = 1'b0;
      cpu_rd(2'b00, rd);
      chk("t4_rd1", rd, 64'h1);
      chk("t4_ri_back", 64'(net_ri), 64'd1);
      cpu_rd(2'b01, rd);
      chk("t4_stat_drop", rd, 64'h8000_0000_0000_0007);
      cpu_rd(2'b01, rd);
      chk("t4_stat_clr", rd, 64'h0000_0000_0000_0007);
      net_si = 1'b1;
      net_di = 64'h5;
      step();
      net_si = 1'b0;
      net_si = 1'b1;
      net_di = 64'h77;
      cpu_rd(2'b01, rd);
      net_si = 1'b0;
      chk("t4_sim_rd", rd, 64'h0000_0000_0000_0009);
      cpu_rd(2'b01, rd);
      chk("t4_sim_set", rd, 64'h8000_0000_0000_0009);
      cpu_rd(2'b01, rd);
      chk("t4_sim_clr", rd, 64'h0000_0000_0000_0009);

      // T5: same-cycle network push and cpu pop
      cpu_rd(2'b00, rd);
      chk("t5_rd2", rd, 64'h2);
      cpu_rd(2'b00, rd);
      chk("t5_rd3", rd, 64'h3);
      net_si = 1'b1;
      net_di = 64'h6;
      cpu_rd(2'b00, rd);
      net_si = 1'b0;
      chk("t5_rd4", rd, 64'h4);
      cpu_rd(2'b01, rd);
      chk("t5_stat", rd, 64'h0000_0000_0000_0005);
      cpu_rd(2'b00, rd);
      chk("t5_rd5", rd, 64'h5);
      cpu_rd(2'b00, rd);
      chk("t5_rd6", rd, 64'h6);
      cpu_rd(2'b01, rd);
      chk("t5_stat_empty", rd, 64'd0);

      // T6: empty read, dead addresses, ignored writes
      cpu_rd(2'b00, rd);
      chk("t6_rd_empty", rd, 64'd0);
      cpu_rd(2'b01, rd);
      chk("t6_stat", rd, 64'd0);
      chk("t6_ri", 64'(net_ri), 64'd1);
      cpu_wr(2'b00, 64'hDEAD);
      cpu_wr(2'b01, 64'hBEEF);
      cpu_wr(2'b11, 64'hCAFE);
      cpu_rd(2'b01, rd);
      chk("t6_wr_ign_in", rd, 64'd0);
      cpu_rd(2'b11, rd);
      chk("t6_wr_ign_out", rd, 64'd0);
      net_si = 1'b1;
      net_di = 64'hAB;
      step();
      net_si = 1'b0;
      addr = 2'b00;
      #1;
      chk("t6_idle_dout", d_out, 64'd0);
      cpu_rd(2'b10, rd);
      chk("t6_rd_outdata", rd, 64'd0);
      cpu_rd(2'b00, rd);
      chk("t6_rd_ab", rd, 64'hAB);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
